// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master: frame FSM states and latched mode bits.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    CPHA_DLY,
    P0,
    P1,
    CS_HOLD
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

endpackage

// File: rtl/spi_clk_div.sv
// Phase timer: counts 0..dvsr_i and ticks phase_end_o on the last cycle of each phase.
module spi_clk_div #(
  parameter int DVSR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic [DVSR_W-1:0] dvsr_i,
  output logic              phase_end_o
);

  logic [DVSR_W-1:0] cnt_q, cnt_d;

  assign phase_end_o = (cnt_q == dvsr_i);

  always_comb begin
    cnt_d = cnt_q + DVSR_W'(1);
    if (clr_i || phase_end_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master with per-frame latched mode, bit order, divider and chip select.
// Optional SPI_MASTER_LOOPBACK_EN adds loopback_i to feed internal MOSI into the RX path.
module spi_master_param
  import spi_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DVSR_W = 16,
  parameter  int NUM_CS = 1,
  localparam int CS_W   = $clog2(NUM_CS > 1 ? NUM_CS : 2)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] din_i,
  input  logic [DVSR_W-1:0] dvsr_i,
  input  logic              start_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic [CS_W-1:0]   cs_sel_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              done_tick_o,
  output logic              ready_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [NUM_CS-1:0] cs_no
`ifdef SPI_MASTER_LOOPBACK_EN
  ,
  input  logic              loopback_i
`endif
);

  localparam int CNT_W = $clog2(DATA_W);

  spi_state_t        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [DVSR_W-1:0] dvsr_q, dvsr_d;
  logic [CS_W-1:0]   cs_sel_q, cs_sel_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic              sclk_q, sclk_d;
  logic [NUM_CS-1:0] cs_q, cs_d;
  logic              phase_end, done, p_clk, rx_bit;

  spi_clk_div #(.DVSR_W(DVSR_W)) u_clk_div (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (state_q == IDLE),
    .dvsr_i      (dvsr_q),
    .phase_end_o (phase_end)
  );

  assign mosi_o = mode_q.lsb_first ? tx_q[0] : tx_q[DATA_W-1];
`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = loopback_i ? mosi_o : miso_i;
`else
  assign rx_bit = miso_i;
`endif

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    dvsr_d   = dvsr_q;
    cs_sel_d = cs_sel_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    dout_d   = dout_q;
    n_d      = n_q;
    done     = 1'b0;
    unique case (state_q)
      IDLE: if (start_i) begin
        state_d          = CS_SETUP;
        mode_d.cpol      = cpol_i;
        mode_d.cpha      = cpha_i;
        mode_d.lsb_first = lsb_first_i;
        dvsr_d           = dvsr_i;
        cs_sel_d         = cs_sel_i;
        tx_d             = din_i;
        n_d              = '0;
      end
      CS_SETUP: if (phase_end) state_d = mode_q.cpha ? CPHA_DLY : P0;
      CPHA_DLY: if (phase_end) state_d = P0;
      P0: if (phase_end) begin
        // RX fills from the end that keeps dout_o in the same bit order as din_i
        rx_d    = mode_q.lsb_first ? {rx_bit, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], rx_bit};
        state_d = P1;
      end
      P1: if (phase_end) begin
        if (n_q == CNT_W'(DATA_W - 1)) begin
          state_d = CS_HOLD;
        end else begin
          tx_d    = mode_q.lsb_first ? {1'b0, tx_q[DATA_W-1:1]} : {tx_q[DATA_W-2:0], 1'b0};
          n_d     = n_q + CNT_W'(1);
          state_d = P0;
        end
      end
      CS_HOLD: if (phase_end) begin
        done    = 1'b1;
        dout_d  = rx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // SCLK and CS are registered from the next state so pads change on clean edges
    p_clk  = ((state_d == P1) && !mode_d.cpha) || ((state_d == P0) && mode_d.cpha);
    sclk_d = (state_d == IDLE) ? cpol_i : (p_clk ^ mode_d.cpol);
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      cs_d[i] = !((state_d != IDLE) && (cs_sel_d == CS_W'(i)));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      dvsr_q   <= '0;
      cs_sel_q <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      dout_q   <= '0;
      n_q      <= '0;
      sclk_q   <= 1'b0;
      cs_q     <= '1;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      dvsr_q   <= dvsr_d;
      cs_sel_q <= cs_sel_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      dout_q   <= dout_d;
      n_q      <= n_d;
      sclk_q   <= sclk_d;
      cs_q     <= cs_d;
    end
  end

  assign dout_o      = dout_q;
  assign done_tick_o = done;
  assign ready_o     = (state_q == IDLE);
  assign sclk_o      = sclk_q;
  assign cs_no       = cs_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param (DATA_W=8, NUM_CS=3) against a phase-schedule model.
module tb_spi_master_param;

  localparam int N   = 8;
  localparam int NCS = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   din = '0;
  logic [15:0]    dvsr = '0;
  logic           start = 1'b0, cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
  logic [1:0]     sel = '0;
  logic [N-1:0]   dout_o;
  logic           done_tick_o, ready_o, sclk_o, mosi_o, miso;
  logic [NCS-1:0] cs_no;

  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(N), .DVSR_W(16), .NUM_CS(NCS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .din_i(din), .dvsr_i(dvsr), .start_i(start),
    .cpol_i(cpol), .cpha_i(cpha), .lsb_first_i(lsb), .cs_sel_i(sel),
    .dout_o(dout_o), .done_tick_o(done_tick_o), .ready_o(ready_o), .sclk_o(sclk_o),
    .mosi_o(mosi_o), .miso_i(miso), .cs_no(cs_no)
`ifdef SPI_MASTER_LOOPBACK_EN
    , .loopback_i(1'b0)
`endif
  );

  // Slave side of the bench
  logic         loop_mode = 1'b0;
  logic [N-1:0] slave_word = '0;

  // Frame model: m_k is the cycle index inside the frame (0 = idle)
  int           m_k = 0, m_len = 0, m_d = 1, m_cpha = 0, m_sel = 0;
  logic         m_cpol = 1'b0, m_lsb = 1'b0;
  logic [N-1:0] m_din = '0, m_slave = '0, m_frame_dout = '0, exp_dout = '0;
  logic         seen_edge = 1'b0, cpol_seen = 1'b0;
  int           done_cnt = 0;

  function automatic logic [N-1:0] rev(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) rev[i] = v[N-1-i];
  endfunction

  // Index of the SCLK half-period (0..2N-1) that cycle k falls in, or -1 outside data phases
  function automatic int data_j(input int k, input int d, input int ph);
    int p, j;
    if (k <= 0) return -1;
    p = (k - 1) / d;
    j = p - 1 - ph;
    return (j >= 0 && j < 2 * N) ? j : -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k       <= 0;
      exp_dout  <= '0;
      seen_edge <= 1'b0;
    end else begin
      seen_edge <= 1'b1;
      cpol_seen <= cpol;
      if (m_k == 0) begin
        if (start) begin
          m_k          <= 1;
          m_d          <= int'(dvsr) + 1;
          m_len        <= (int'(dvsr) + 1) * (2 * N + 2 + int'(cpha));
          m_cpol       <= cpol;
          m_cpha       <= int'(cpha);
          m_lsb        <= lsb;
          m_sel        <= int'(sel);
          m_din        <= din;
          m_slave      <= slave_word;
          m_frame_dout <= loop_mode ? din : (lsb ? rev(slave_word) : slave_word);
        end
      end else if (m_k == m_len) begin
        m_k      <= 0;
        exp_dout <= m_frame_dout;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  always @(posedge clk) if (done_tick_o) done_cnt <= done_cnt + 1;

  // Slave drives MSB-first from the model's schedule, or echoes MOSI
  int   sched_j;
  logic sched_bit;
  always_comb begin
    sched_j   = data_j(m_k, m_d, m_cpha);
    sched_bit = 1'b0;
    if (sched_j >= 0) sched_bit = m_slave[N - 1 - sched_j / 2];
  end
  assign miso = loop_mode ? mosi_o : sched_bit;

  // Literal expectations captured by the stimulus and checked by the compare process
  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } pin_t;
  pin_t pins [64];
  int   pin_wr = 0;
  int   pin_rd = 0;

  task automatic pin(input string nm, input logic [31:0] a, input logic [31:0] e);
    pins[pin_wr] = '{name: nm, act: a, exp: e};
    pin_wr++;
  endtask

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    int           j;
    logic         esclk;
    logic [NCS-1:0] ecs;
    while (pin_rd < pin_wr) begin
      check(pins[pin_rd].name, pins[pin_rd].act, pins[pin_rd].exp);
      pin_rd++;
    end
    if (!rst_n) begin
      check("rst_ready", ready_o, 1);
      check("rst_done", done_tick_o, 0);
      check("rst_sclk", sclk_o, 0);
      check("rst_cs", cs_no, 3'b111);
      check("rst_dout", dout_o, 0);
    end else begin
      for (int i = 0; i < NCS; i++) ecs[i] = !(m_k != 0 && m_sel == i);
      j = data_j(m_k, m_d, m_cpha);
      if (m_k == 0) esclk = seen_edge ? cpol_seen : 1'b0;
      else if (j >= 0) esclk = m_cpol ^ ((m_cpha != 0) ? (j % 2 == 0) : (j % 2 == 1));
      else esclk = m_cpol;
      check("ready", ready_o, (m_k == 0));
      check("done", done_tick_o, (m_k != 0 && m_k == m_len));
      check("cs", cs_no, ecs);
      check("sclk", sclk_o, esclk);
      check("dout", dout_o, exp_dout);
      if (j >= 0) check("mosi", mosi_o, m_lsb ? m_din[j / 2] : m_din[N - 1 - j / 2]);
    end
  end

  task automatic do_frame(input logic [N-1:0] d, input logic [15:0] dv, input logic pol,
                          input logic ph, input logic lf, input logic [1:0] s,
                          input logic [N-1:0] sw, input logic lp, input logic disturb,
                          input int abort_at, output int len, output int tog,
                          output logic [NCS-1:0] csmid);
    int   n;
    logic prev;
    @(posedge clk); #1;
    din = d; dvsr = dv; cpol = pol; cpha = ph; lsb = lf; sel = s;
    slave_word = sw; loop_mode = lp; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; tog = 0; prev = sclk_o; csmid = '1;
    while (!done_tick_o && n < 4000) begin
      if (n == 5) csmid = cs_no;
      if (disturb && n == 10) begin
        start = 1'b1; dvsr = 16'd7; din = '1; cpol = ~cpol; lsb = ~lsb;
      end
      if (disturb && n == 12) start = 1'b0;
      if (abort_at > 0 && n == abort_at) begin
        rst_n = 1'b0;
        len = n;
        return;
      end
      @(posedge clk); #1;
      n++;
      if (sclk_o !== prev) tog++;
      prev = sclk_o;
    end
    len = n;
    if (disturb) start = 1'b1;  // request in the done cycle must be dropped
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int             len, tog, dc;
    logic [NCS-1:0] csm;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    pin("reset_ready", ready_o, 1);
    pin("reset_cs", cs_no, 3'b111);

    // mode 0, MSB first, MOSI echoed back
    do_frame(8'hA5, 16'd3, 0, 0, 0, 2'd0, 8'h00, 1, 0, 0, len, tog, csm);
    pin("t1_len", len, 72);
    pin("t1_dout", dout_o, 8'hA5);
    pin("t1_edges", tog, 16);
    pin("t1_cs", csm, 3'b110);

    // mode 3, dvsr 0
    do_frame(8'h3C, 16'd0, 1, 1, 0, 2'd1, 8'hC3, 0, 0, 0, len, tog, csm);
    pin("t2_len", len, 19);
    pin("t2_dout", dout_o, 8'hC3);
    pin("t2_edges", tog, 16);
    pin("t2_cs", csm, 3'b101);
    pin("t2_sclk_idle", sclk_o, 1);

    // LSB first against an MSB-first slave returning 0x80
    do_frame(8'h01, 16'd1, 0, 1, 1, 2'd0, 8'h80, 0, 0, 0, len, tog, csm);
    pin("t3_len", len, 38);
    pin("t3_dout", dout_o, 8'h01);

    // chip select decode, including an index beyond NUM_CS
    do_frame(8'h69, 16'd0, 0, 0, 0, 2'd2, 8'h5E, 0, 0, 0, len, tog, csm);
    pin("t4_cs2", csm, 3'b011);
    pin("t4_len", len, 18);
    pin("t4_dout", dout_o, 8'h5E);
    dc = done_cnt;
    do_frame(8'h0F, 16'd0, 0, 0, 0, 2'd3, 8'hF0, 0, 0, 0, len, tog, csm);
    pin("t4_cs3", csm, 3'b111);
    pin("t4b_len", len, 18);
    pin("t4b_done", done_cnt - dc, 1);

    // mid-frame start/dvsr/mode changes and start in the done cycle
    do_frame(8'h5A, 16'd2, 1, 0, 0, 2'd0, 8'h00, 1, 1, 0, len, tog, csm);
    pin("t5_len", len, 54);
    pin("t5_dout", dout_o, 8'h5A);
    pin("t5_ready", ready_o, 1);

    // reset during bit 4
    dc = done_cnt;
    do_frame(8'hF0, 16'd1, 0, 0, 0, 2'd1, 8'h00, 1, 0, 19, len, tog, csm);
    #2;
    pin("t6_sclk", sclk_o, 0);
    pin("t6_cs", cs_no, 3'b111);
    pin("t6_ready", ready_o, 1);
    pin("t6_done", done_tick_o, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    pin("t6_no_done", done_cnt - dc, 0);
    pin("t6_dout", dout_o, 0);
    do_frame(8'h96, 16'd0, 0, 0, 0, 2'd0, 8'h00, 1, 0, 0, len, tog, csm);
    pin("t6_len", len, 18);
    pin("t6_new_dout", dout_o, 8'h96);

    repeat (2) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
